// File: rtl/control_unit_pkg.sv
// Shared definitions for the multicycle LEGv8-subset controller: ALU function
// codes, opcodes, control-word bit positions, status flag indices and state types.
package control_unit_pkg;

  localparam int CW_WIDTH = 25;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01010;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam int CW_ALU_EN      = 24;
  localparam int CW_B_SEL       = 23;
  localparam int CW_FS_LSB      = 18;
  localparam int CW_SEL_A_LSB   = 13;
  localparam int CW_SEL_B_LSB   = 8;
  localparam int CW_WR_ADDR_LSB = 3;
  localparam int CW_REG_WRITE   = 2;
  localparam int CW_RAM_EN      = 1;
  localparam int CW_RAM_WRITE   = 0;

  localparam int STATUS_Z = 0;
  localparam int STATUS_N = 1;
  localparam int STATUS_C = 2;
  localparam int STATUS_V = 3;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    BR_NONE   = 2'd0,
    BR_UNCOND = 2'd1,
    BR_CBZ    = 2'd2
  } branch_kind_t;

  // ram_write is left at 0: the datapath has no store path.
  function automatic logic [CW_WIDTH-1:0] pack_cw(
    input logic       alu_en,
    input logic       b_sel,
    input logic [4:0] fs,
    input logic [4:0] sel_a,
    input logic [4:0] sel_b,
    input logic [4:0] wr_addr,
    input logic       reg_write,
    input logic       ram_en
  );
    logic [CW_WIDTH-1:0] cw;
    cw = '0;
    cw[CW_ALU_EN]                = alu_en;
    cw[CW_B_SEL]                 = b_sel;
    cw[CW_FS_LSB +: 5]           = fs;
    cw[CW_SEL_A_LSB +: 5]        = sel_a;
    cw[CW_SEL_B_LSB +: 5]        = sel_b;
    cw[CW_WR_ADDR_LSB +: 5]      = wr_addr;
    cw[CW_REG_WRITE]             = reg_write;
    cw[CW_RAM_EN]                = ram_en;
    cw[CW_RAM_WRITE]             = 1'b0;
    return cw;
  endfunction

endpackage

// File: rtl/control_unit_decoder.sv
// Combinational decode of a latched instruction into control word, immediate
// and branch information; unmatched encodings are flagged illegal.
module instruction_decoder
  import control_unit_pkg::*;
(
  input  logic [31:0]         ir,
  output logic [CW_WIDTH-1:0] controlword,
  output logic [63:0]         immediate,
  output branch_kind_t        branch_kind,
  output logic [63:0]         branch_offset,
  output logic                illegal
);

  logic [4:0] rd;
  logic [4:0] rn;
  logic [4:0] rm;

  assign rd = ir[4:0];
  assign rn = ir[9:5];
  assign rm = ir[20:16];

  // Longest opcode fields are tested first so shorter ones cannot alias them.
  always_comb begin
    controlword   = '0;
    immediate     = '0;
    branch_kind   = BR_NONE;
    branch_offset = '0;
    illegal       = 1'b0;
    if (ir[31:21] == OP_ADD) begin
      controlword = pack_cw(1'b1, 1'b0, FS_ADD, rn, rm, rd, 1'b1, 1'b0);
    end else if (ir[31:21] == OP_SUB) begin
      controlword = pack_cw(1'b1, 1'b0, FS_SUB, rn, rm, rd, 1'b1, 1'b0);
    end else if (ir[31:21] == OP_AND) begin
      controlword = pack_cw(1'b1, 1'b0, FS_AND, rn, rm, rd, 1'b1, 1'b0);
    end else if (ir[31:21] == OP_ORR) begin
      controlword = pack_cw(1'b1, 1'b0, FS_OR, rn, rm, rd, 1'b1, 1'b0);
    end else if (ir[31:21] == OP_LDUR) begin
      controlword = pack_cw(1'b0, 1'b1, FS_ADD, rn, 5'd0, rd, 1'b1, 1'b1);
      immediate   = {{55{ir[20]}}, ir[20:12]};
    end else if (ir[31:22] == OP_ADDI) begin
      controlword = pack_cw(1'b1, 1'b1, FS_ADD, rn, 5'd0, rd, 1'b1, 1'b0);
      immediate   = {52'd0, ir[21:10]};
    end else if (ir[31:22] == OP_SUBI) begin
      controlword = pack_cw(1'b1, 1'b1, FS_SUB, rn, 5'd0, rd, 1'b1, 1'b0);
      immediate   = {52'd0, ir[21:10]};
    end else if (ir[31:24] == OP_CBZ) begin
      // Rt is routed through the ALU so the Z flag reflects Rt == 0.
      controlword   = pack_cw(1'b0, 1'b1, FS_ADD, rd, 5'd0, 5'd0, 1'b0, 1'b0);
      branch_kind   = BR_CBZ;
      branch_offset = {{43{ir[23]}}, ir[23:5], 2'b00};
    end else if (ir[31:26] == OP_B) begin
      branch_kind   = BR_UNCOND;
      branch_offset = {{36{ir[25]}}, ir[25:0], 2'b00};
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle FETCH/DECODE/EXECUTE controller: owns pc, ir and the halt flag and
// presents the decoded control word and immediate only during EXECUTE.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         instruction,
  input  logic [3:0]          status,
  output logic [PC_WIDTH-1:0] instr_address,
  output logic [CW_WIDTH-1:0] controlword,
  output logic [63:0]         immediate,
  output logic                halted
);

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_next;
  logic [31:0]         ir;

  logic [CW_WIDTH-1:0] dec_cw;
  logic [63:0]         dec_imm;
  branch_kind_t        dec_branch_kind;
  logic [63:0]         dec_offset;
  logic                dec_illegal;
  logic                unused_flags;

  instruction_decoder u_decoder (
    .ir            (ir),
    .controlword   (dec_cw),
    .immediate     (dec_imm),
    .branch_kind   (dec_branch_kind),
    .branch_offset (dec_offset),
    .illegal       (dec_illegal)
  );

  assign instr_address = pc;
  assign unused_flags  = ^status[3:1];

  // Gated by the state register, so an async reset clears these immediately.
  assign controlword = (state == ST_EXECUTE) ? dec_cw  : '0;
  assign immediate   = (state == ST_EXECUTE) ? dec_imm : '0;

  always_comb begin
    pc_next = pc + PC_WIDTH'(4);
    if (dec_branch_kind == BR_UNCOND ||
        (dec_branch_kind == BR_CBZ && status[STATUS_Z])) begin
      pc_next = pc + dec_offset[PC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          ir    <= instruction;
          state <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          if (dec_illegal) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            pc    <= pc_next;
            state <= ST_FETCH;
          end
        end
        ST_HALT: state <= ST_HALT;
      endcase
    end
  end

endmodule
